// File: rtl/bsg_ruche_link_arbiter.sv
// Wormhole-aware round-robin merge of ruche link streams onto one outgoing link.
// The output is locked to one input for a whole packet: the header plus len body flits.
module bsg_ruche_link_arbiter #(
    parameter int unsigned flit_width_p   = 16,
    parameter int unsigned ruche_factor_p = 4,
    parameter int unsigned cord_width_p   = 4,
    parameter int unsigned len_width_p    = 3,
    localparam int unsigned lg_rf_lp      = (ruche_factor_p <= 1) ? 1 : $clog2(ruche_factor_p)
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [ruche_factor_p-1:0]              v_i,
    input  logic [ruche_factor_p*flit_width_p-1:0] data_i,
    output logic [ruche_factor_p-1:0]              ready_and_o,
    output logic                                   v_o,
    output logic [flit_width_p-1:0]                data_o,
    input  logic                                   ready_and_i,
    output logic                                   busy_o,
    output logic [lg_rf_lp-1:0]                    sel_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                 state_r, state_n;
    logic [lg_rf_lp-1:0]    lock_r, lock_n;
    logic [lg_rf_lp-1:0]    rr_last_r, rr_last_n;
    logic [len_width_p-1:0] count_r, count_n;

    logic                   busy;
    logic                   grant_v;
    logic [lg_rf_lp-1:0]    grant_idx;
    logic [lg_rf_lp-1:0]    cur_idx;
    logic                   cur_v;
    logic                   xfer;
    logic [len_width_p-1:0] hdr_len;

    assign busy = (state_r == StBusy);

    // Round-robin search starting one past the last header winner.
    always_comb begin : p_grant
        int unsigned cand;
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= ruche_factor_p; i++) begin
            cand = (32'(rr_last_r) + i) % ruche_factor_p;
            if (!grant_v && v_i[cand]) begin
                grant_v   = 1'b1;
                grant_idx = lg_rf_lp'(cand);
            end
        end
    end

    always_comb begin
        cur_idx     = busy ? lock_r : grant_idx;
        cur_v       = busy ? v_i[lock_r] : grant_v;
        v_o         = cur_v & ~reset_i;
        data_o      = data_i[cur_idx*flit_width_p +: flit_width_p];
        ready_and_o = '0;
        // In BUSY the locked input sees ready even while it is not valid.
        if (!reset_i && (busy || grant_v)) begin
            ready_and_o[cur_idx] = ready_and_i;
        end
        sel_o  = cur_idx;
        busy_o = busy;
    end

    assign xfer    = v_o & ready_and_i;
    assign hdr_len = data_o[cord_width_p +: len_width_p];

    always_comb begin
        state_n   = state_r;
        lock_n    = lock_r;
        rr_last_n = rr_last_r;
        count_n   = count_r;
        unique case (state_r)
            StIdle: begin
                if (xfer) begin
                    rr_last_n = grant_idx;
                    if (hdr_len != '0) begin
                        lock_n  = grant_idx;
                        count_n = hdr_len;
                        state_n = StBusy;
                    end
                end
            end
            StBusy: begin
                if (xfer) begin
                    count_n = count_r - 1'b1;
                    if (count_r == len_width_p'(1)) begin
                        state_n = StIdle;
                    end
                end
            end
            default: state_n = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= StIdle;
            lock_r    <= '0;
            rr_last_r <= lg_rf_lp'(ruche_factor_p - 1);
            count_r   <= '0;
        end else begin
            state_r   <= state_n;
            lock_r    <= lock_n;
            rr_last_r <= rr_last_n;
            count_r   <= count_n;
        end
    end

endmodule

// File: tb/tb_bsg_ruche_link_arbiter.sv
// Directed bench for bsg_ruche_link_arbiter with 4 inputs, 16-bit flits, 3-bit len field.
module tb_bsg_ruche_link_arbiter;

    localparam int unsigned W  = 16;
    localparam int unsigned RF = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [RF-1:0] vin;
    logic [W-1:0]  din [RF];
    logic [RF*W-1:0] data_flat;
    logic [RF-1:0] ready_and_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          ready_and_i;
    logic          busy_o;
    logic [1:0]    sel_o;

    int nvec = 0;
    int nerr = 0;

    assign data_flat = {din[3], din[2], din[1], din[0]};

    always #5 clk = ~clk;

    bsg_ruche_link_arbiter #(
        .flit_width_p  (16),
        .ruche_factor_p(4),
        .cord_width_p  (4),
        .len_width_p   (3)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .v_i        (vin),
        .data_i     (data_flat),
        .ready_and_o(ready_and_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .ready_and_i(ready_and_i),
        .busy_o     (busy_o),
        .sel_o      (sel_o)
    );

    // Header: {tag[8:0], len[2:0], cord[3:0]}
    function automatic logic [15:0] hdr(input logic [2:0] len, input logic [8:0] tag);
        return {tag, len, 4'h0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset       = 1'b1;
        vin         = 4'hF;
        ready_and_i = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = hdr(3'd0, 9'(k));
        step();
        settle();
        chk("reset_v_o", 32'(v_o), 32'h0);
        chk("reset_ready", 32'(ready_and_o), 32'h0);
        step();
        reset = 1'b0;
        vin   = 4'h0;
        settle();
        chk("idle_busy", 32'(busy_o), 32'h0);
        chk("idle_v_o", 32'(v_o), 32'h0);
        chk("idle_sel", 32'(sel_o), 32'h0);

        // Single packet from input 0, len=2.
        vin    = 4'b0001;
        din[0] = hdr(3'd2, 9'h011);
        settle();
        chk("sp_hdr_v", 32'(v_o), 32'h1);
        chk("sp_hdr_data", 32'(data_o), 32'(hdr(3'd2, 9'h011)));
        chk("sp_hdr_ready", 32'(ready_and_o), 32'h1);
        chk("sp_hdr_busy", 32'(busy_o), 32'h0);
        step();
        din[0] = 16'hB001;
        settle();
        chk("sp_b1_busy", 32'(busy_o), 32'h1);
        chk("sp_b1_data", 32'(data_o), 32'hB001);
        chk("sp_b1_ready", 32'(ready_and_o), 32'h1);
        step();
        din[0] = 16'hB002;
        settle();
        chk("sp_b2_busy", 32'(busy_o), 32'h1);
        chk("sp_b2_v", 32'(v_o), 32'h1);
        step();
        vin = 4'h0;
        settle();
        chk("sp_tail_idle", 32'(busy_o), 32'h0);
        chk("sp_tail_v", 32'(v_o), 32'h0);

        // Round robin from reset: len=0 headers on all inputs.
        reset = 1'b1;
        step();
        reset = 1'b0;
        vin   = 4'hF;
        for (int k = 0; k < 4; k++) din[k] = hdr(3'd0, 9'(k + 8'h20));
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rr_sel", 32'(sel_o), 32'(i % 4));
            chk("rr_ready", 32'(ready_and_o), 32'(1 << (i % 4)));
            chk("rr_data", 32'(data_o), 32'(hdr(3'd0, 9'((i % 4) + 8'h20))));
            chk("rr_busy", 32'(busy_o), 32'h0);
            step();
        end

        // Lock: input 1 len=3 while input 0 stays valid; last winner was 0.
        vin    = 4'b0011;
        din[0] = hdr(3'd0, 9'h055);
        din[1] = hdr(3'd3, 9'h033);
        settle();
        chk("lk_hdr_sel", 32'(sel_o), 32'h1);
        chk("lk_hdr_data", 32'(data_o), 32'(hdr(3'd3, 9'h033)));
        step();
        for (int b = 0; b < 3; b++) begin
            din[1] = 16'hC000 + 16'(b);
            settle();
            chk("lk_body_sel", 32'(sel_o), 32'h1);
            chk("lk_body_ready", 32'(ready_and_o), 32'h2);
            chk("lk_body_data", 32'(data_o), 32'hC000 + 32'(b));
            chk("lk_body_busy", 32'(busy_o), 32'h1);
            step();
        end
        vin    = 4'b0111;
        din[2] = hdr(3'd0, 9'h022);
        settle();
        chk("lk_next_sel2", 32'(sel_o), 32'h2);
        chk("lk_next_busy", 32'(busy_o), 32'h0);
        step();
        vin = 4'b0011;
        settle();
        chk("lk_next_sel0", 32'(sel_o), 32'h0);
        chk("lk_next_data0", 32'(data_o), 32'(hdr(3'd0, 9'h055)));
        step();

        // Backpressure: input 3 len=2, ready pattern 1,0,0,1,1.
        vin    = 4'b1000;
        din[3] = hdr(3'd2, 9'h0BB);
        settle();
        chk("bp_hdr_sel", 32'(sel_o), 32'h3);
        chk("bp_hdr_ready", 32'(ready_and_o), 32'h8);
        step();
        din[3]      = 16'hD001;
        ready_and_i = 1'b0;
        settle();
        chk("bp_stall1_ready", 32'(ready_and_o), 32'h0);
        chk("bp_stall1_data", 32'(data_o), 32'hD001);
        chk("bp_stall1_v", 32'(v_o), 32'h1);
        step();
        settle();
        chk("bp_stall2_data", 32'(data_o), 32'hD001);
        chk("bp_stall2_busy", 32'(busy_o), 32'h1);
        step();
        ready_and_i = 1'b1;
        settle();
        chk("bp_b1_ready", 32'(ready_and_o), 32'h8);
        step();
        din[3] = 16'hD002;
        settle();
        chk("bp_b2_busy", 32'(busy_o), 32'h1);
        chk("bp_b2_data", 32'(data_o), 32'hD002);
        step();
        vin = 4'h0;
        settle();
        chk("bp_tail_idle", 32'(busy_o), 32'h0);

        // Reset mid-packet: input 2 len=5, reset after two bodies.
        vin    = 4'b0100;
        din[2] = hdr(3'd5, 9'h0CC);
        settle();
        chk("rm_hdr_sel", 32'(sel_o), 32'h2);
        step();
        din[2] = 16'hE001;
        step();
        din[2] = 16'hE002;
        step();
        din[2] = 16'hE003;
        din[0] = hdr(3'd0, 9'h0AA);
        vin    = 4'b0101;
        reset  = 1'b1;
        settle();
        chk("rm_reset_v", 32'(v_o), 32'h0);
        chk("rm_reset_ready", 32'(ready_and_o), 32'h0);
        step();
        reset = 1'b0;
        settle();
        chk("rm_after_busy", 32'(busy_o), 32'h0);
        chk("rm_after_sel", 32'(sel_o), 32'h0);
        chk("rm_after_data", 32'(data_o), 32'(hdr(3'd0, 9'h0AA)));
        step();

        // Max length: len=7 from input 2, bodies carry a nonzero len field.
        vin    = 4'b0100;
        din[2] = hdr(3'd7, 9'h0DD);
        settle();
        chk("ml_hdr_sel", 32'(sel_o), 32'h2);
        step();
        for (int b = 0; b < 7; b++) begin
            din[2] = 16'h0070 | 16'(b << 8);
            settle();
            chk("ml_body_busy", 32'(busy_o), 32'h1);
            chk("ml_body_ready", 32'(ready_and_o), 32'h4);
            step();
        end
        din[2] = hdr(3'd0, 9'h0EE);
        settle();
        chk("ml_tail_idle", 32'(busy_o), 32'h0);
        chk("ml_next_v", 32'(v_o), 32'h1);
        step();
        vin = 4'h0;
        settle();
        chk("ml_no_wrap", 32'(busy_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
